// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, exception type codes, ExcCode values and reset values.
package cp0_reg_pkg;

    typedef enum logic [4:0] {
        CP0_COUNT   = 5'd9,
        CP0_COMPARE = 5'd11,
        CP0_STATUS  = 5'd12,
        CP0_CAUSE   = 5'd13,
        CP0_EPC     = 5'd14,
        CP0_PRID    = 5'd15,
        CP0_CONFIG  = 5'd16
    } cp0_addr_e;

    localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;
    localparam logic [4:0] EXCCODE_TR  = 5'd13;
    localparam logic [4:0] EXCCODE_OV  = 5'd12;

    localparam logic [31:0] STATUS_RESET  = 32'h1000_0000;
    localparam logic [31:0] COUNT_RESET   = 32'h0000_0000;
    localparam logic [31:0] COMPARE_RESET = 32'h0000_0000;
    localparam logic [31:0] CAUSE_RESET   = 32'h0000_0000;
    localparam logic [31:0] EPC_RESET     = 32'h0000_0000;

    // Cause bits software may change with mtc0: IP[1:0], IV, WP.
    localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer; only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        timer_int_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg     <= COUNT_RESET;
            compare_reg   <= COMPARE_RESET;
            timer_int_reg <= 1'b0;
        end else begin
            count_reg <= count_reg + 32'd1;
            if (count_reg == compare_reg && compare_reg != 32'd0)
                timer_int_reg <= 1'b1;
            if (we_i && waddr_i == CP0_COUNT)
                count_reg <= data_i;
            // Writing Compare acknowledges the interrupt, even against a match this same edge.
            if (we_i && waddr_i == CP0_COMPARE) begin
                compare_reg   <= data_i;
                timer_int_reg <= 1'b0;
            end
        end
    end

    assign count_o     = count_reg;
    assign compare_o   = compare_reg;
    assign timer_int_o = timer_int_reg;

endmodule

// File: rtl/cp0_reg.sv
// MIPS CP0 register file: mtc0/mfc0 access, exception/eret state updates, optional timer.
// Define CP0_TIMER_EN to build in the Count/Compare timer; otherwise Count/Compare read 0.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic [31:0] status_reg;
    logic [31:0] cause_reg;
    logic [31:0] epc_reg;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .data_i      (data_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );
`else
    assign count_o     = 32'd0;
    assign compare_o   = 32'd0;
    assign timer_int_o = 1'b0;
`endif

    logic        exc_valid;
    logic        exc_sync;
    logic [4:0]  exc_code;
    logic [31:0] epc_target;

    always_comb begin
        exc_valid = 1'b1;
        exc_sync  = 1'b1;
        exc_code  = EXCCODE_INT;
        case (excepttype_i)
            EXC_INTERRUPT:    exc_sync = 1'b0;
            EXC_SYSCALL:      exc_code = EXCCODE_SYS;
            EXC_INST_INVALID: exc_code = EXCCODE_RI;
            EXC_TRAP:         exc_code = EXCCODE_TR;
            EXC_OVERFLOW:     exc_code = EXCCODE_OV;
            EXC_ERET:         exc_sync = 1'b0;
            default: begin
                exc_valid = 1'b0;
                exc_sync  = 1'b0;
            end
        endcase
    end

    // Delay-slot instructions restart at the branch, one word earlier.
    assign epc_target = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_reg <= STATUS_RESET;
            cause_reg  <= CAUSE_RESET;
            epc_reg    <= EPC_RESET;
        end else begin
            cause_reg[15:10] <= int_i;
            if (excepttype_i == EXC_INTERRUPT) begin
                epc_reg        <= epc_target;
                cause_reg[31]  <= is_in_delayslot_i;
                status_reg[1]  <= 1'b1;
                cause_reg[6:2] <= EXCCODE_INT;
            end else if (excepttype_i == EXC_ERET) begin
                status_reg[1] <= 1'b0;
            end else if (exc_sync) begin
                // Nested exceptions keep the EPC of the outermost one.
                if (!status_reg[1]) begin
                    epc_reg       <= epc_target;
                    cause_reg[31] <= is_in_delayslot_i;
                end
                status_reg[1]  <= 1'b1;
                cause_reg[6:2] <= exc_code;
            end else if (we_i && !exc_valid) begin
                case (waddr_i)
                    CP0_STATUS: status_reg <= data_i;
                    CP0_EPC:    epc_reg    <= data_i;
                    CP0_CAUSE: begin
                        cause_reg[9:8]   <= data_i[9:8];
                        cause_reg[23:22] <= data_i[23:22];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_COUNT:   data_o = count_o;
            CP0_COMPARE: data_o = compare_o;
            CP0_STATUS:  data_o = status_reg;
            CP0_CAUSE:   data_o = cause_reg;
            CP0_EPC:     data_o = epc_reg;
            CP0_PRID:    data_o = PRID_VALUE;
            CP0_CONFIG:  data_o = CONFIG_VALUE;
            default:     data_o = 32'd0;
        endcase
    end

    assign status_o = status_reg;
    assign cause_o  = cause_reg;
    assign epc_o    = epc_reg;
    assign config_o = CONFIG_VALUE;
    assign prid_o   = PRID_VALUE;

endmodule
